// File: rtl/twisted_ring_counter_pkg.sv
// trc_pkg: shared mode/direction encodings and reset pattern for the twisted ring counter
package trc_pkg;
  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING = 1'b1;
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;
  function automatic logic [31:0] trc_reset_pattern(input int width);
    return 32'(1) << (width - 1);
  endfunction
endpackage

// File: rtl/twisted_ring_counter_if.sv
// twisted_ring_counter_if: control inputs and counter outputs of the twisted ring counter
interface twisted_ring_counter_if #(
  parameter int WIDTH = 5,
  localparam int PHASE_W = $clog2(2 * WIDTH)
);
  logic en;
  logic mode;
  logic dir;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [PHASE_W-1:0] phase;
  logic wrap;
  logic illegal;
  modport master (output en, mode, dir, load, load_val, input q, phase, wrap, illegal);
  modport slave (input en, mode, dir, load, load_val, output q, phase, wrap, illegal);
endinterface

// File: rtl/twisted_ring_counter_decode.sv
// trc_decode: legality check and phase index of a counter value for the selected mode
module trc_decode
  import trc_pkg::*;
#(
  parameter int WIDTH = 5,
  localparam int PHASE_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic mode,
  output logic legal,
  output logic [PHASE_W-1:0] phase
);
  logic [WIDTH-2:0] t;
  logic [PHASE_W-1:0] ones;
  logic [PHASE_W-1:0] idx;
  logic [PHASE_W-1:0] j_phase;
  logic j_legal;
  logic r_legal;
  // Johnson is legal with at most one adjacent-bit transition; ring needs exactly one set bit
  always_comb begin
    ones = '0;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + PHASE_W'(q[i]);
      idx = q[i] ? PHASE_W'(WIDTH - 1 - i) : idx;
    end
    t = q[WIDTH-1:1] ^ q[WIDTH-2:0];
    j_legal = (t & (t - (WIDTH-1)'(1))) == '0;
    r_legal = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
    legal = (mode == MODE_RING) ? r_legal : j_legal;
    j_phase = q[WIDTH-1] ? ones - PHASE_W'(1) : PHASE_W'(2 * WIDTH - 1) - ones;
    phase = !legal ? '0 : (mode == MODE_RING) ? idx : j_phase;
  end
endmodule

// File: rtl/twisted_ring_counter.sv
// twisted_ring_counter: Johnson/ring sequence counter with load, direction, wrap and self-correction
module twisted_ring_counter
  import trc_pkg::*;
#(
  parameter int WIDTH = 5,
  localparam int PHASE_W = $clog2(2 * WIDTH)
) (
  input logic clk,
  input logic reset,
  twisted_ring_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] RST_PAT = WIDTH'(trc_reset_pattern(WIDTH));
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] shifted;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] last;
  logic legal;
  logic step;
  logic wrap;
  logic wrap_nxt;
  logic illegal;
  logic ill_nxt;
  trc_decode #(.WIDTH(WIDTH)) u_dec (
    .q(q),
    .mode(bus.mode),
    .legal(legal),
    .phase(phase)
  );
  // next state: load wins over stepping; an illegal value is replaced by the reset pattern on a step
  always_comb begin
    step = bus.en && !bus.load;
    last = (bus.mode == MODE_RING) ? PHASE_W'(WIDTH - 1) : PHASE_W'(2 * WIDTH - 1);
    shifted = (bus.mode == MODE_RING)
      ? ((bus.dir == DIR_FWD) ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]})
      : ((bus.dir == DIR_FWD) ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]});
    q_nxt = bus.load ? bus.load_val : !step ? q : legal ? shifted : RST_PAT;
    wrap_nxt = step && legal && ((bus.dir == DIR_FWD) ? (phase == last) : (phase == '0));
    ill_nxt = step && !legal;
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RST_PAT;
      wrap <= 1'b0;
      illegal <= 1'b0;
    end else begin
      q <= q_nxt;
      wrap <= wrap_nxt;
      illegal <= ill_nxt;
    end
  end
  assign bus.q = q;
  assign bus.phase = phase;
  assign bus.wrap = wrap;
  assign bus.illegal = illegal;
endmodule

// File: tb/tb_twisted_ring_counter.sv
// tb_twisted_ring_counter: scoreboard bench driving directed vectors into the twisted ring counter
module tb_twisted_ring_counter;
  import trc_pkg::*;
  localparam int WIDTH = 5;
  localparam int PHASE_W = $clog2(2 * WIDTH);
  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [PHASE_W-1:0] phase;
    logic wrap;
    logic illegal;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  string name_q[$];
  twisted_ring_counter_if #(.WIDTH(WIDTH)) bus ();
  twisted_ring_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic drv(input logic r, input logic ld, input logic [WIDTH-1:0] lv, input logic e,
                     input logic m, input logic d, input logic [WIDTH-1:0] eq, input int eph,
                     input logic ew, input logic ei, input string nm);
    exp_t x;
    @(negedge clk);
    reset = r;
    bus.load = ld;
    bus.load_val = lv;
    bus.en = e;
    bus.mode = m;
    bus.dir = d;
    x.q = eq;
    x.phase = PHASE_W'(eph);
    x.wrap = ew;
    x.illegal = ei;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask
  task automatic step(input logic m, input logic d, input logic [WIDTH-1:0] eq, input int eph,
                      input logic ew, input logic ei, input string nm);
    drv(1'b1, 1'b0, '0, 1'b1, m, d, eq, eph, ew, ei, nm);
  endtask
  task automatic hold(input logic m, input logic [WIDTH-1:0] eq, input int eph, input string nm);
    drv(1'b1, 1'b0, '0, 1'b0, m, DIR_FWD, eq, eph, 1'b0, 1'b0, nm);
  endtask
  task automatic ld(input logic m, input logic [WIDTH-1:0] lv, input int eph, input string nm);
    drv(1'b1, 1'b1, lv, 1'b0, m, DIR_FWD, lv, eph, 1'b0, 1'b0, nm);
  endtask
  // monitor: compare the DUT against the oldest expectation just after each active edge
  always begin
    exp_t e;
    string n;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if ({bus.q, bus.phase, bus.wrap, bus.illegal} !== e) begin
        bad++;
        $display("FAIL %s: got q=%b phase=%0d wrap=%b illegal=%b, want q=%b phase=%0d wrap=%b illegal=%b",
                 n, bus.q, bus.phase, bus.wrap, bus.illegal, e.q, e.phase, e.wrap, e.illegal);
      end
    end
  end
  initial begin
    bus.en = 1'b0;
    bus.mode = MODE_JOHNSON;
    bus.dir = DIR_FWD;
    bus.load = 1'b0;
    bus.load_val = '0;
    drv(1'b0, 1'b0, '0, 1'b0, MODE_JOHNSON, DIR_FWD, 5'b10000, 0, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 3; i++) hold(MODE_JOHNSON, 5'b10000, 0, "hold");
    step(MODE_JOHNSON, DIR_FWD, 5'b11000, 1, 1'b0, 1'b0, "jf1");
    step(MODE_JOHNSON, DIR_FWD, 5'b11100, 2, 1'b0, 1'b0, "jf2");
    step(MODE_JOHNSON, DIR_FWD, 5'b11110, 3, 1'b0, 1'b0, "jf3");
    step(MODE_JOHNSON, DIR_FWD, 5'b11111, 4, 1'b0, 1'b0, "jf4");
    step(MODE_JOHNSON, DIR_FWD, 5'b01111, 5, 1'b0, 1'b0, "jf5");
    step(MODE_JOHNSON, DIR_FWD, 5'b00111, 6, 1'b0, 1'b0, "jf6");
    step(MODE_JOHNSON, DIR_FWD, 5'b00011, 7, 1'b0, 1'b0, "jf7");
    step(MODE_JOHNSON, DIR_FWD, 5'b00001, 8, 1'b0, 1'b0, "jf8");
    step(MODE_JOHNSON, DIR_FWD, 5'b00000, 9, 1'b0, 1'b0, "jf9");
    step(MODE_JOHNSON, DIR_FWD, 5'b10000, 0, 1'b1, 1'b0, "jf_wrap");
    step(MODE_JOHNSON, DIR_REV, 5'b00000, 9, 1'b1, 1'b0, "jr_wrap");
    step(MODE_JOHNSON, DIR_FWD, 5'b10000, 0, 1'b1, 1'b0, "jf_back");
    step(MODE_JOHNSON, DIR_FWD, 5'b11000, 1, 1'b0, 1'b0, "jdir_a");
    step(MODE_JOHNSON, DIR_REV, 5'b10000, 0, 1'b0, 1'b0, "jdir_b");
    step(MODE_JOHNSON, DIR_REV, 5'b00000, 9, 1'b1, 1'b0, "jdir_c");
    step(MODE_JOHNSON, DIR_FWD, 5'b10000, 0, 1'b1, 1'b0, "jdir_d");
    step(MODE_RING, DIR_FWD, 5'b01000, 1, 1'b0, 1'b0, "rf1");
    step(MODE_RING, DIR_FWD, 5'b00100, 2, 1'b0, 1'b0, "rf2");
    step(MODE_RING, DIR_FWD, 5'b00010, 3, 1'b0, 1'b0, "rf3");
    step(MODE_RING, DIR_FWD, 5'b00001, 4, 1'b0, 1'b0, "rf4");
    step(MODE_RING, DIR_FWD, 5'b10000, 0, 1'b1, 1'b0, "rf_wrap");
    step(MODE_RING, DIR_REV, 5'b00001, 4, 1'b1, 1'b0, "rr_wrap");
    hold(MODE_RING, 5'b00001, 4, "r_hold");
    ld(MODE_JOHNSON, 5'b10100, 0, "j_ld_bad");
    step(MODE_JOHNSON, DIR_FWD, 5'b10000, 0, 1'b0, 1'b1, "j_fix");
    hold(MODE_JOHNSON, 5'b10000, 0, "j_fix_hold");
    ld(MODE_RING, 5'b11000, 0, "r_ld_bad");
    step(MODE_RING, DIR_FWD, 5'b10000, 0, 1'b0, 1'b1, "r_fix");
    ld(MODE_JOHNSON, 5'b11100, 2, "ms_ld");
    step(MODE_RING, DIR_FWD, 5'b10000, 0, 1'b0, 1'b1, "mode_sw");
    drv(1'b1, 1'b1, 5'b00111, 1'b1, MODE_JOHNSON, DIR_FWD, 5'b00111, 6, 1'b0, 1'b0, "ld_over_en");
    drv(1'b0, 1'b1, 5'b01010, 1'b1, MODE_JOHNSON, DIR_FWD, 5'b10000, 0, 1'b0, 1'b0, "rst_over_ld");
    hold(MODE_JOHNSON, 5'b10000, 0, "final_hold");
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/twisted_ring_counter.md
Name: twisted_ring_counter

Overview:
- Parametrised shift-register sequence counter with two modes: Johnson (twisted ring, 2*WIDTH states) and one-hot ring (WIDTH states).
- Adds over the fixed 5-bit counter: count enable, up/down direction, parallel load, phase index output, wrap pulse, and self-correction of illegal states.
- Used as a phase/sequence generator for multi-phase control and timing logic.

Parameters:
- WIDTH, 5, register length in bits; minimum 2.
- PHASE_W, $clog2(2*WIDTH), localparam; width of the phase index.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-low.
- en  input  1  advance one step this cycle.
- mode  input  1  0 = Johnson, 1 = ring.
- dir  input  1  0 = forward (shift toward LSB), 1 = reverse (shift toward MSB).
- load  input  1  parallel load of load_val.
- load_val  input  WIDTH  value written on load.
- q  output  WIDTH  counter register.
- phase  output  PHASE_W  decoded step index of q.
- wrap  output  1  registered one-cycle pulse marking sequence wrap.
- illegal  output  1  registered one-cycle pulse marking a self-correction.

Behaviour:
- Reset and clock: reset is synchronous and active-low; clock is clk.
- Priority per posedge: reset=0 > load=1 > en=1 > hold.
- Reset values:
  - q = 1 in MSB, all other bits 0 (10000 for WIDTH=5); this pattern is legal in both modes.
  - wrap = 0, illegal = 0, phase = 0.
- Load:
  - q <= load_val verbatim, even if the value is illegal.
  - wrap <= 0, illegal <= 0.
- Step (en=1, load=0):
  - If q is legal for the current mode, apply the shift rule for that mode:
    - Johnson forward: q <= {~q[0], q[WIDTH-1:1]}
    - Johnson reverse: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}
    - Ring forward: q <= {q[0], q[WIDTH-1:1]}
    - Ring reverse: q <= {q[WIDTH-2:0], q[WIDTH-1]}
  - If q is illegal for the current mode: q <= reset pattern, illegal <= 1, wrap <= 0.
- Hold (en=0, load=0): q unchanged; wrap <= 0, illegal <= 0.
- Legality:
  - Johnson: q is one of the 2*WIDTH patterns of the form 1..10..0 or 0..01..1, where the all-ones and all-zeros patterns both count as legal.
  - Ring: exactly one bit of q is set.
- Phase (combinational from q and mode):
  - Johnson, MSB=1: phase = ones(q) - 1 (10000 -> 0, 11111 -> 4).
  - Johnson, MSB=0: phase = 2*WIDTH - 1 - ones(q) (01111 -> 5, 00000 -> 9).
  - Ring: phase = index of the set bit counted from the MSB (10000 -> 0, 00001 -> 4).
  - When q is illegal: phase = 0.
- Wrap:
  - Set to 1 for exactly one cycle after a legal step that moves phase from LAST to 0 (forward) or from 0 to LAST (reverse).
  - LAST = 2*WIDTH-1 in Johnson mode, WIDTH-1 in ring mode.
  - A correction step never asserts wrap.
- Mode change:
  - Takes effect on the next step.
  - A state that is legal in the old mode but illegal in the new one is corrected on that step.
- Direction change mid-sequence: the next step moves to the adjacent phase with no skipped state.
- Reset mid-operation overrides load and en in the same cycle.
- Latency: q, wrap and illegal update one clock after the qualifying inputs; phase follows q combinationally.

Decomposition:
- Shared package trc_pkg:
  - MODE_JOHNSON=1'b0, MODE_RING=1'b1
  - DIR_FWD=1'b0, DIR_REV=1'b1
  - function trc_reset_pattern(WIDTH)
- Sub-module trc_decode: combinational, takes q and mode, produces legal and phase; instantiated once.

Test Plan:
- Reset and hold: WIDTH=5, reset=0 for one edge -> q=10000, phase=0, wrap=0, illegal=0. Then en=0 for 3 cycles -> q holds 10000.
- Johnson forward: mode=0, dir=0, en=1 for 10 cycles from 10000 -> q = 11000, 11100, 11110, 11111, 01111, 00111, 00011, 00001, 00000, 10000; phase 1..9 then 0; wrap=1 only on the 10th step.
- Johnson reverse and ring mode:
  - Johnson, dir=1 from 10000 -> q=00000, phase=9, wrap=1.
  - Ring, mode=1, dir=0 from 10000 for 5 steps -> 01000, 00100, 00010, 00001, 10000; wrap on step 5.
  - Ring, dir=1 from 10000 -> 00001.
- Illegal correction:
  - load=1, load_val=10100, mode=0 -> q=10100, phase=0.
  - Next en=1 -> q=10000, illegal=1 for one cycle, wrap=0.
  - Repeat with mode=1 and load_val=11000 -> same correction.
- Mode switch: Johnson q=11100, set mode=1, en=1 -> q=10000, illegal=1.
- Priority: load=1, en=1, load_val=00111 -> q=00111, no shift. Then reset=0 together with load=1 -> q=10000.
